// File: rtl/interp_pkg.sv
// Shared constants, state encoding and step-class table for the interpolation sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package interp_pkg;

    localparam int N_SC     = 12;   // subcarriers per NB-IoT RB, one step each
    localparam int SEL_W    = 3;    // operand-select width
    localparam int IDX_W    = 4;    // subcarrier index width
    localparam int VSHIFT_W = 3;

    // Largest legal NRS frequency shift; 6 and 7 are rejected at start.
    localparam logic [VSHIFT_W-1:0] VSHIFT_MAX = 3'd5;

    // Step counter values with special meaning.
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_SC - 1);
    localparam logic [IDX_W-1:0] K_EXTRAP = 4'd9;   // steps 9..11 extrapolate from 4E4

    // add2 operand mux select codes.
    localparam logic [SEL_W-1:0] SEL_2E1  = 3'b000;
    localparam logic [SEL_W-1:0] SEL_E1   = 3'b001;
    localparam logic [SEL_W-1:0] SEL_2E2  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_4E4  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_E3   = 3'b110;
    localparam logic [SEL_W-1:0] SEL_REG  = 3'b100;
    localparam logic [SEL_W-1:0] SEL_ZERO = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel_a;
        logic [SEL_W-1:0] sel_b;
        logic             reg_en;
    } step_ctl_t;

    // Step class table, indexed by k mod 3. Class 0 reloads the shared
    // register; classes 1 and 2 add the register contents to a new operand.
    function automatic step_ctl_t class_ctl(input logic [1:0] cls);
        step_ctl_t ctl;
        case (cls)
            2'd0:    ctl = '{sel_a: SEL_E1,  sel_b: SEL_ZERO, reg_en: 1'b1};
            2'd1:    ctl = '{sel_a: SEL_2E1, sel_b: SEL_REG,  reg_en: 1'b0};
            2'd2:    ctl = '{sel_a: SEL_2E2, sel_b: SEL_REG,  reg_en: 1'b0};
            default: ctl = '{sel_a: SEL_ZERO, sel_b: SEL_ZERO, reg_en: 1'b0};
        endcase
        return ctl;
    endfunction

    // (k + v_shift) mod N_SC; the sum never exceeds 11 + 5, so one
    // conditional subtract is enough.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0]    k,
                                                   input logic [VSHIFT_W-1:0] vs);
        logic [IDX_W:0] sum;
        sum = {1'b0, k} + {2'b00, vs};
        if (sum >= (IDX_W+1)'(N_SC)) begin
            sum = sum - (IDX_W+1)'(N_SC);
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/interp_seq_ctrl_if.sv
// Handshake/control bundle between the interpolation sequencer and its neighbours.
// Latency: n/a (wires only).
// Backpressure: out_ready from the estimate buffer side stalls the current step.
// Ports: start/v_shift/out_ready into the sequencer; sel_a/sel_b/reg_en/out_valid/
//        sc_idx/busy/done/cfg_err out of it. slave = sequencer, master = its driver.
interface interp_seq_ctrl_if;
    import interp_pkg::*;

    logic                start;
    logic [VSHIFT_W-1:0] v_shift;
    logic                out_ready;
    logic [SEL_W-1:0]    sel_a;
    logic [SEL_W-1:0]    sel_b;
    logic                reg_en;
    logic                out_valid;
    logic [IDX_W-1:0]    sc_idx;
    logic                busy;
    logic                done;
    logic                cfg_err;

    modport master (
        output start, v_shift, out_ready,
        input  sel_a, sel_b, reg_en, out_valid, sc_idx, busy, done, cfg_err
    );

    modport slave (
        input  start, v_shift, out_ready,
        output sel_a, sel_b, reg_en, out_valid, sc_idx, busy, done, cfg_err
    );

endinterface

// File: rtl/interp_step_rom.sv
// Step decode: step index k -> operand selects and shared-register load enable.
// Latency: combinational.
// Backpressure: none; the caller decides when k advances.
// Ports: k (step index) in; sel_a, sel_b, reg_en out.
module interp_step_rom
    import interp_pkg::*;
(
    input  logic [IDX_W-1:0] k,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             reg_en
);

    logic [1:0] cls;
    step_ctl_t  ctl;

    always_comb begin
        cls    = 2'(k % IDX_W'(3));
        ctl    = class_ctl(cls);
        sel_a  = ctl.sel_a;
        sel_b  = ctl.sel_b;
        reg_en = ctl.reg_en;
        // The last pilot interval has no E5 to interpolate towards, so the
        // tail steps extrapolate from 4E4 while keeping the class b/reg_en.
        if (k >= K_EXTRAP) begin
            sel_a = SEL_4E4;
        end
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Interpolation sequencer: latch v_shift, prime the 2E register, walk 12 subcarrier steps.
// Latency: start -> LOAD next cycle, first valid step 2 cycles after start, done 14 with no stall.
// Backpressure: out_ready=0 holds every output (reg_en forced low) until the step is accepted.
// Ports: clk, rst (sync, active-low); bus (slave): start, v_shift, out_ready in;
//        sel_a, sel_b, reg_en, out_valid, sc_idx, busy, done, cfg_err out (all registered).
module interp_seq_ctrl
    import interp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    interp_seq_ctrl_if.slave  bus
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [VSHIFT_W-1:0] vs_q, vs_d;

    logic [SEL_W-1:0]    sel_a_q, sel_a_d;
    logic [SEL_W-1:0]    sel_b_q, sel_b_d;
    logic                reg_en_q, reg_en_d;
    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    sc_idx_q, sc_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    // Outputs are registered, so the ROM is addressed with the step that
    // will be presented next: step 0 while in LOAD, k+1 while in RUN.
    logic [IDX_W-1:0]    rom_k;
    logic [SEL_W-1:0]    rom_sel_a;
    logic [SEL_W-1:0]    rom_sel_b;
    logic                rom_reg_en;
    logic                accept;

    always_comb begin
        rom_k = '0;
        if (state_q == ST_RUN) begin
            rom_k = k_q + 1'b1;
        end
    end

    interp_step_rom u_step_rom (
        .k      (rom_k),
        .sel_a  (rom_sel_a),
        .sel_b  (rom_sel_b),
        .reg_en (rom_reg_en)
    );

    assign accept = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        vs_d        = vs_q;
        sel_a_d     = SEL_ZERO;
        sel_b_d     = SEL_ZERO;
        reg_en_d    = 1'b0;
        out_valid_d = 1'b0;
        sc_idx_d    = sc_idx_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.v_shift <= VSHIFT_MAX) begin
                        state_d  = ST_LOAD;
                        vs_d     = bus.v_shift;
                        k_d      = '0;
                        // Prime the shared register with 2E1.
                        sel_a_d  = SEL_2E1;
                        reg_en_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                state_d     = ST_RUN;
                k_d         = '0;
                sel_a_d     = rom_sel_a;
                sel_b_d     = rom_sel_b;
                reg_en_d    = rom_reg_en;
                out_valid_d = 1'b1;
                sc_idx_d    = wrap_idx(rom_k, vs_q);
                busy_d      = 1'b1;
            end

            ST_RUN: begin
                busy_d = 1'b1;
                if (accept) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d         = rom_k;
                        sel_a_d     = rom_sel_a;
                        sel_b_d     = rom_sel_b;
                        reg_en_d    = rom_reg_en;
                        out_valid_d = 1'b1;
                        sc_idx_d    = wrap_idx(rom_k, vs_q);
                    end
                end else begin
                    // Hold the step; a repeated register load would corrupt
                    // the accumulated 2E value, so reg_en drops while stalled.
                    sel_a_d     = sel_a_q;
                    sel_b_d     = sel_b_q;
                    out_valid_d = 1'b1;
                end
            end

            ST_DONE: begin
                // start is deliberately ignored here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            vs_q        <= '0;
            sel_a_q     <= SEL_ZERO;
            sel_b_q     <= SEL_ZERO;
            reg_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sc_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            vs_q        <= vs_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            reg_en_q    <= reg_en_d;
            out_valid_q <= out_valid_d;
            sc_idx_q    <= sc_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.sel_a     = sel_a_q;
    assign bus.sel_b     = sel_b_q;
    assign bus.reg_en    = reg_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sc_idx    = sc_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Self-checking bench for interp_seq_ctrl: directed sequence table, corner cases, random runs.
// Latency: n/a.
// Backpressure: out_ready driven from the table (fixed stalls) or randomly.
module tb_interp_seq_ctrl;

    localparam int NSTEP = 12;

    logic clk;
    logic rst;

    interp_seq_ctrl_if bus();

    interp_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected step outputs derived directly from the step table.
    typedef struct {
        int a;
        int b;
        int en;
        int idx;
    } exp_t;

    // One directed sequence: shift, stall position/length, a start pulse
    // during step restart_k, a start pulse in the done cycle, expected done cycle.
    typedef struct {
        int vs;
        int stall_k;
        int stall_len;
        int restart_k;
        int done_start;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_step(input int k, input int vs);
        exp_t e;
        case (k % 3)
            0:       begin e.a = 1; e.b = 7; e.en = 1; end
            1:       begin e.a = 0; e.b = 4; e.en = 0; end
            default: begin e.a = 3; e.b = 4; e.en = 0; end
        endcase
        if (k >= 9) e.a = 2;
        e.idx = (k + vs) % NSTEP;
        return e;
    endfunction

    task automatic chk_reset(input string p);
        chk({p, "_sel_a"},     int'(bus.sel_a), 7);
        chk({p, "_sel_b"},     int'(bus.sel_b), 7);
        chk({p, "_reg_en"},    int'(bus.reg_en), 0);
        chk({p, "_out_valid"}, int'(bus.out_valid), 0);
        chk({p, "_sc_idx"},    int'(bus.sc_idx), 0);
        chk({p, "_busy"},      int'(bus.busy), 0);
        chk({p, "_done"},      int'(bus.done), 0);
        chk({p, "_cfg_err"},   int'(bus.cfg_err), 0);
    endtask

    // Runs one legal sequence from IDLE, checking every cycle against the model.
    task automatic run_seq(input int vs, input int stall_k, input int stall_len,
                           input int restart_k, input int done_start, input bit rnd,
                           output int done_cyc, output int acc, output int ndone);
        int   cyc;
        int   k;
        int   stl;
        bit   fresh;
        bit   rdy;
        bit   fin;
        exp_t e;
        done_cyc = -1; acc = 0; ndone = 0; k = 0; stl = 0; fresh = 1'b1; fin = 1'b0;

        bus.start = 1'b1; bus.v_shift = 3'(vs); bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        chk("load_reg_en",    int'(bus.reg_en), 1);
        chk("load_sel_a",     int'(bus.sel_a), 0);
        chk("load_sel_b",     int'(bus.sel_b), 7);
        chk("load_out_valid", int'(bus.out_valid), 0);
        chk("load_busy",      int'(bus.busy), 1);
        chk("load_cfg_err",   int'(bus.cfg_err), 0);
        tick();
        cyc = 2;

        while (!fin && cyc < 80) begin
            if (bus.done) ndone++;
            if (k < NSTEP) begin
                e = model_step(k, vs);
                chk($sformatf("step%0d_out_valid", k), int'(bus.out_valid), 1);
                chk($sformatf("step%0d_busy", k),      int'(bus.busy), 1);
                chk($sformatf("step%0d_done", k),      int'(bus.done), 0);
                chk($sformatf("step%0d_cfg_err", k),   int'(bus.cfg_err), 0);
                chk($sformatf("step%0d_sel_a", k),     int'(bus.sel_a), e.a);
                chk($sformatf("step%0d_sel_b", k),     int'(bus.sel_b), e.b);
                chk($sformatf("step%0d_reg_en", k),    int'(bus.reg_en), fresh ? e.en : 0);
                chk($sformatf("step%0d_sc_idx", k),    int'(bus.sc_idx), e.idx);
                if (rnd) begin
                    rdy = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 5) == 0) begin
                        bus.start   = 1'b1;
                        bus.v_shift = 3'($urandom_range(0, 7));
                    end
                end else if (k == stall_k && stl < stall_len) begin
                    rdy = 1'b0;
                    stl++;
                end else begin
                    rdy = 1'b1;
                end
                if (k == restart_k && fresh) begin
                    bus.start   = 1'b1;
                    bus.v_shift = 3'((vs + 1) % 6);
                end
                bus.out_ready = rdy;
                if (rdy && bus.out_valid) acc++;
                if (rdy) begin
                    k++;
                    fresh = 1'b1;
                end else begin
                    fresh = 1'b0;
                end
            end else if (done_cyc < 0) begin
                done_cyc = cyc;
                chk("done_pulse",     int'(bus.done), 1);
                chk("done_out_valid", int'(bus.out_valid), 0);
                chk("done_sel_a",     int'(bus.sel_a), 7);
                chk("done_sel_b",     int'(bus.sel_b), 7);
                chk("done_reg_en",    int'(bus.reg_en), 0);
                chk("done_busy",      int'(bus.busy), 1);
                if (done_start != 0) begin
                    bus.start   = 1'b1;
                    bus.v_shift = 3'(vs);
                end
            end else begin
                chk("post_done",      int'(bus.done), 0);
                chk("post_busy",      int'(bus.busy), 0);
                chk("post_out_valid", int'(bus.out_valid), 0);
                chk("post_reg_en",    int'(bus.reg_en), 0);
                chk("post_cfg_err",   int'(bus.cfg_err), 0);
                fin = 1'b1;
            end
            if (!fin) begin
                tick();
                bus.start = 1'b0;
                cyc++;
            end
        end
        if (!fin) chk("seq_timeout", 0, 1);
        bus.out_ready = 1'b1;
    endtask

    task automatic run_illegal(input int vs);
        bus.start = 1'b1; bus.v_shift = 3'(vs);
        tick();
        bus.start = 1'b0;
        chk($sformatf("illegal%0d_cfg_err", vs), int'(bus.cfg_err), 1);
        chk($sformatf("illegal%0d_busy", vs),    int'(bus.busy), 0);
        chk($sformatf("illegal%0d_reg_en", vs),  int'(bus.reg_en), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("illegal%0d_cfg_err_after", vs), int'(bus.cfg_err), 0);
            chk($sformatf("illegal%0d_out_valid", vs),     int'(bus.out_valid), 0);
            chk($sformatf("illegal%0d_busy_after", vs),    int'(bus.busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int dc;
        int acc;
        int nd;

        vecs[0] = '{vs: 0, stall_k: -1, stall_len: 0, restart_k: -1, done_start: 0, exp_done: 14};
        vecs[1] = '{vs: 5, stall_k: -1, stall_len: 0, restart_k: -1, done_start: 0, exp_done: 14};
        vecs[2] = '{vs: 0, stall_k:  4, stall_len: 3, restart_k: -1, done_start: 0, exp_done: 17};
        vecs[3] = '{vs: 3, stall_k: -1, stall_len: 0, restart_k:  6, done_start: 0, exp_done: 14};
        vecs[4] = '{vs: 4, stall_k:  0, stall_len: 2, restart_k: -1, done_start: 1, exp_done: 16};
        vecs[5] = '{vs: 1, stall_k: 11, stall_len: 1, restart_k: -1, done_start: 0, exp_done: 15};

        rst = 1'b0;
        bus.start = 1'b0; bus.v_shift = '0; bus.out_ready = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].vs, vecs[i].stall_k, vecs[i].stall_len, vecs[i].restart_k,
                    vecs[i].done_start, 1'b0, dc, acc, nd);
            chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk($sformatf("vec%0d_accepts", i), acc, NSTEP);
            chk($sformatf("vec%0d_done_count", i), nd, 1);
        end

        run_illegal(6);
        run_illegal(7);

        // Reset during step 8: outputs return to reset values, no done pulse.
        bus.start = 1'b1; bus.v_shift = 3'd2; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_pre_sc_idx", int'(bus.sc_idx), (8 + 2) % NSTEP);
        chk("abort_pre_valid",  int'(bus.out_valid), 1);
        rst = 1'b0;
        tick();
        chk_reset("abort");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_after_done",  int'(bus.done), 0);
            chk("abort_after_valid", int'(bus.out_valid), 0);
            chk("abort_after_busy",  int'(bus.busy), 0);
        end
        run_seq(0, -1, 0, -1, 0, 1'b0, dc, acc, nd);
        chk("abort_rerun_done_cycle", dc, 14);
        chk("abort_rerun_accepts", acc, NSTEP);
        chk("abort_rerun_done_count", nd, 1);

        // Random sequences with random back-pressure and stray start pulses.
        for (int i = 0; i < 24; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r >= 6) begin
                run_illegal(r);
            end else begin
                run_seq(r, -1, 0, -1, int'($urandom_range(0, 1)), 1'b1, dc, acc, nd);
                chk($sformatf("rnd%0d_accepts", i), acc, NSTEP);
                chk($sformatf("rnd%0d_done_count", i), nd, 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
